// File: rtl/puf_pkg.sv
// Shared types and default widths for the arbiter-PUF reader.
package puf_pkg;

  localparam int PUF_CHAL_W = 32;
  localparam int PUF_RESP_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    FIRE,
    SAMPLE,
    DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_sync.sv
// Two-flop synchroniser bank for the asynchronous PUF response bits.
module puf_sync #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] sync_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      dout    <= '0;
    end else begin
      sync_p0 <= din;
      dout    <= sync_p0;
    end
  end

endmodule

// File: rtl/puf_reader.sv
// Arbiter-PUF initiator: NUM_EVAL races per challenge, per-bit majority vote of the synchronised ID.
// Optional per-bit disagreement mask when PUF_READER_STABILITY_EN is defined.
module puf_reader
  import puf_pkg::*;
#(
  parameter int CHAL_W     = PUF_CHAL_W,
  parameter int RESP_W     = PUF_RESP_W,
  parameter int PRE_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_EVAL   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [CHAL_W-1:0] req_challenge_i,
  output logic              puf_enable_o,
  output logic [CHAL_W-1:0] puf_challenge_o,
  input  logic [RESP_W-1:0] puf_id_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RESP_W-1:0] rsp_id_o,
  output logic [RESP_W-1:0] rsp_unstable_o
);

  localparam int MAX_CYC = max_int(PRE_CYC, SETTLE_CYC);
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int EVAL_W  = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;
  localparam int CNT_W   = $clog2(NUM_EVAL + 1);

  if ((NUM_EVAL < 1) || (NUM_EVAL % 2 == 0)) begin : g_bad_num_eval
    $error("puf_reader: NUM_EVAL must be odd and >= 1");
  end
  if (SETTLE_CYC < 3) begin : g_bad_settle
    $error("puf_reader: SETTLE_CYC must be >= 3 to cover the synchroniser");
  end
  if (PRE_CYC < 1) begin : g_bad_pre
    $error("puf_reader: PRE_CYC must be >= 1");
  end

  state_e             state;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [EVAL_W-1:0]  eval_cnt;
  logic [CNT_W-1:0]   ones_cnt [RESP_W];
  logic [RESP_W-1:0]  sync_id;
  logic [RESP_W-1:0]  vote;
  logic               accept;

  puf_sync #(.DATA_W(RESP_W)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .din   (puf_id_i),
    .dout  (sync_id)
  );

  assign accept = (state == IDLE) && req_valid_i && req_ready_o;

  always_comb begin
    vote = '0;
    for (int i = 0; i < RESP_W; i++) begin
      vote[i] = ones_cnt[i] > CNT_W'(NUM_EVAL / 2);
    end
  end

  // Vote counters carry no reset: they are cleared on every accepted request.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < RESP_W; i++) ones_cnt[i] <= '0;
    end else if (state == SAMPLE) begin
      for (int i = 0; i < RESP_W; i++) ones_cnt[i] <= ones_cnt[i] + CNT_W'(sync_id[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      eval_cnt        <= '0;
      req_ready_o     <= 1'b0;
      puf_enable_o    <= 1'b0;
      puf_challenge_o <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_id_o        <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            req_ready_o     <= 1'b0;
            puf_challenge_o <= req_challenge_i;
            eval_cnt        <= '0;
            cyc_cnt         <= '0;
            state           <= PRE;
          end
        end
        PRE: begin
          if (cyc_cnt == CYC_W'(PRE_CYC - 1)) begin
            cyc_cnt      <= '0;
            puf_enable_o <= 1'b1;
            state        <= FIRE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        FIRE: begin
          if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
            cyc_cnt <= '0;
            state   <= SAMPLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          puf_enable_o <= 1'b0;
          if (eval_cnt == EVAL_W'(NUM_EVAL - 1)) begin
            state <= DONE;
          end else begin
            eval_cnt <= eval_cnt + 1'b1;
            state    <= PRE;
          end
        end
        DONE: begin
          // First DONE cycle registers the vote taken from the final SAMPLE update.
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= vote;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PUF_READER_STABILITY_EN
  logic [RESP_W-1:0] unstable;

  always_comb begin
    unstable = '0;
    for (int i = 0; i < RESP_W; i++) begin
      unstable[i] = (ones_cnt[i] != '0) && (ones_cnt[i] != CNT_W'(NUM_EVAL));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_unstable_o <= '0;
    end else if ((state == DONE) && !rsp_valid_o) begin
      rsp_unstable_o <= unstable;
    end
  end
`else
  assign rsp_unstable_o = '0;
`endif

endmodule
